hazard_ctrl: RTL and testbench

Pipeline hazard controller for the rv32i 5-stage core, replacing the fixed branch/JAL stall unit. It inspects the instruction held in IF/ID against the producers in EX and MEM. It drives PC, IF/ID and ID/EX enables and flushes, and the operand-forwarding selects. It also freezes fetch for a parametrised control-hazard penalty after any branch, JAL or JALR.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/hazard_decode.sv | 25 ++
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared rv32i opcode constants and hazard-controller types.
package rv32i_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned RS_W     = 5;

  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_EX  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    CTRL = 1'b1
  } hazard_state_t;

endpackage

// File: rtl/hazard_decode.sv
// Extracts control-flow class and source-register usage from the IF/ID instruction.
module hazard_decode
  import rv32i_pkg::*;
(
  input  logic [31:0]     i_instr,
  output logic            o_is_ctrl,
  output logic            o_uses_rs1,
  output logic            o_uses_rs2,
  output logic [RS_W-1:0] o_rs1,
  output logic [RS_W-1:0] o_rs2
);

  logic [OPCODE_W-1:0] w_op;
  logic                w_unused_bits;

  assign w_op          = i_instr[6:0];
  assign o_rs1         = i_instr[19:15];
  assign o_rs2         = i_instr[24:20];
  assign w_unused_bits = ^{i_instr[31:25], i_instr[14:7]};

  assign o_is_ctrl  = (w_op == OP_BRANCH) || (w_op == OP_JAL) || (w_op == OP_JALR);
  assign o_uses_rs1 = !((w_op == OP_LUI) || (w_op == OP_AUIPC) || (w_op == OP_JAL));
  assign o_uses_rs2 = (w_op == OP_OP) || (w_op == OP_STORE) || (w_op == OP_BRANCH);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW stalls, control-flow fetch freeze, forwarding.
// Build option HAZARD_FORWARD_EN enables operand forwarding; otherwise every RAW match stalls.
module hazard_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned CTRL_PENALTY = 2,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           id_instr,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  output logic                  pc_enable,
  output logic                  ifid_enable,
  output logic                  ifid_flush,
  output logic                  idex_enable,
  output logic                  idex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b
);

  localparam int unsigned CNT_W = $clog2(CTRL_PENALTY + 1);

  hazard_state_t    r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  logic            w_is_ctrl, w_uses_rs1, w_uses_rs2;
  logic [RS_W-1:0] w_rs1, w_rs2;
  logic            w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;
  logic            w_stall;
  fwd_sel_t        w_fwd_a, w_fwd_b;

  hazard_decode u_decode (
    .i_instr    (id_instr),
    .o_is_ctrl  (w_is_ctrl),
    .o_uses_rs1 (w_uses_rs1),
    .o_uses_rs2 (w_uses_rs2),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2)
  );

  // Raw register matches; x0 never matches.
  assign w_rs1_ex  = (w_rs1 != '0) && (REG_ADDR_W'(w_rs1) == ex_rd)  && ex_regwrite;
  assign w_rs2_ex  = (w_rs2 != '0) && (REG_ADDR_W'(w_rs2) == ex_rd)  && ex_regwrite;
  assign w_rs1_mem = (w_rs1 != '0) && (REG_ADDR_W'(w_rs1) == mem_rd) && mem_regwrite;
  assign w_rs2_mem = (w_rs2 != '0) && (REG_ADDR_W'(w_rs2) == mem_rd) && mem_regwrite;

`ifdef HAZARD_FORWARD_EN
  assign w_stall = ex_memread && ((w_uses_rs1 && w_rs1_ex) || (w_uses_rs2 && w_rs2_ex));
  assign w_fwd_a = w_rs1_ex ? FWD_EX : (w_rs1_mem ? FWD_MEM : FWD_RF);
  assign w_fwd_b = w_rs2_ex ? FWD_EX : (w_rs2_mem ? FWD_MEM : FWD_RF);
`else
  logic w_unused_memread;
  assign w_unused_memread = ex_memread;
  assign w_stall = (w_uses_rs1 && (w_rs1_ex || w_rs1_mem)) ||
                   (w_uses_rs2 && (w_rs2_ex || w_rs2_mem));
  assign w_fwd_a = FWD_RF;
  assign w_fwd_b = FWD_RF;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and hazard outputs; reset forces the pass-through defaults.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_enable   = 1'b1;
    ifid_enable = 1'b1;
    ifid_flush  = 1'b0;
    idex_enable = 1'b1;
    idex_flush  = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (rst_n) begin
      fwd_a = w_fwd_a;
      fwd_b = w_fwd_b;
      unique case (r_state)
        IDLE: begin
          if (id_valid && w_stall) begin
            pc_enable   = 1'b0;
            ifid_enable = 1'b0;
            idex_flush  = 1'b1;
          end else if (id_valid && w_is_ctrl) begin
            pc_enable  = 1'b0;
            ifid_flush = 1'b1;
            if (CTRL_PENALTY > 1) begin
              w_state_nxt = CTRL;
              w_cnt_nxt   = CNT_W'(CTRL_PENALTY - 1);
            end
          end
        end
        CTRL: begin
          pc_enable  = 1'b0;
          ifid_flush = 1'b1;
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          if (r_cnt <= CNT_W'(1)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with CTRL_PENALTY=3; expectations follow HAZARD_FORWARD_EN.
module tb_hazard_ctrl;

  localparam int unsigned P = 3;
`ifdef HAZARD_FORWARD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush}
  localparam logic [4:0] DEF    = 5'b11010;
  localparam logic [4:0] STALL  = 5'b00011;
  localparam logic [4:0] FREEZE = 5'b01110;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ12    = 32'h0020_8063;
  localparam logic [31:0] ADD6_5_1 = 32'h0012_8333;
  localparam logic [31:0] SUB4_3_3 = 32'h4031_8233;
  localparam logic [31:0] BNE2_0   = 32'h0001_1063;
  localparam logic [31:0] OR8_7_0  = 32'h0003_E433;
  localparam logic [31:0] LUI_RS5  = 32'h0002_92B7;
  localparam logic [31:0] JAL1     = 32'h0000_00EF;
  localparam logic [31:0] JALR0_1  = 32'h0000_8067;

  logic        clk, rst_n;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [4:0]  ex_rd, mem_rd;
  logic        ex_regwrite, ex_memread, mem_regwrite;
  logic        pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic [1:0]  fwd_a, fwd_b;

  int total = 0;
  int bad   = 0;

  hazard_ctrl #(.CTRL_PENALTY(P), .REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_instr     (id_instr),
    .id_valid     (id_valid),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .pc_enable    (pc_enable),
    .ifid_enable  (ifid_enable),
    .ifid_flush   (ifid_flush),
    .idex_enable  (idex_enable),
    .idex_flush   (idex_flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] instr, input logic valid,
                       input logic [4:0] erd, input logic ew, input logic emr,
                       input logic [4:0] mrd, input logic mw);
    id_instr     = instr;
    id_valid     = valid;
    ex_rd        = erd;
    ex_regwrite  = ew;
    ex_memread   = emr;
    mem_rd       = mrd;
    mem_regwrite = mw;
  endtask

  // Checks outputs mid-cycle (1ns after the falling-edge drive) then waits for the next falling edge.
  task automatic check(input string tag, input logic [4:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb);
    logic [8:0] obs, exp;
    #1;
    obs = {pc_enable, ifid_enable, ifid_flush, idex_enable, idex_flush, fwd_a, fwd_b};
    exp = {ctl, fa, fb};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(NOP, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);
    check("reset_default", DEF, 2'b00, 2'b00);

    rst_n = 1'b1;
    check("idle_nop", DEF, 2'b00, 2'b00);

    // Branch penalty: exactly P frozen cycles, then normal flow.
    drive(BEQ12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("beq_c0", FREEZE, 2'b00, 2'b00);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("beq_c1", FREEZE, 2'b00, 2'b00);
    check("beq_c2", FREEZE, 2'b00, 2'b00);
    check("beq_done", DEF, 2'b00, 2'b00);

    drive(BEQ12, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("beq_invalid", DEF, 2'b00, 2'b00);

    // Reset while in CTRL aborts the penalty.
    drive(BEQ12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst_beq_c0", FREEZE, 2'b00, 2'b00);
    rst_n = 1'b0;
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst_in_ctrl_0", DEF, 2'b00, 2'b00);
    check("rst_in_ctrl_1", DEF, 2'b00, 2'b00);
    rst_n = 1'b1;
    check("rst_released_idle", DEF, 2'b00, 2'b00);
    drive(BEQ12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst_beq2_c0", FREEZE, 2'b00, 2'b00);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("rst_beq2_c1", FREEZE, 2'b00, 2'b00);
    check("rst_beq2_c2", FREEZE, 2'b00, 2'b00);
    check("rst_beq2_done", DEF, 2'b00, 2'b00);

    // Load-use: LW x5 in EX, ADD x6,x5,x1 in ID.
    drive(ADD6_5_1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    check("lu_stall", STALL, FWD_ON ? 2'b10 : 2'b00, 2'b00);
    drive(ADD6_5_1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1);
    check("lu_after", FWD_ON ? DEF : STALL, FWD_ON ? 2'b01 : 2'b00, 2'b00);
    drive(ADD6_5_1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("lu_clear", DEF, 2'b00, 2'b00);

    // Double producer on x3; EX wins.
    drive(SUB4_3_3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1);
    check("fwd_ex_both", FWD_ON ? DEF : STALL, FWD_ON ? 2'b10 : 2'b00, FWD_ON ? 2'b10 : 2'b00);
    drive(SUB4_3_3, 1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 1'b1);
    check("fwd_mem_only", FWD_ON ? DEF : STALL, FWD_ON ? 2'b01 : 2'b00, FWD_ON ? 2'b01 : 2'b00);
    drive(SUB4_3_3, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1);
    check("fwd_x0", DEF, 2'b00, 2'b00);

    // LUI does not read rs1 even if its rs1 field collides with a load destination.
    drive(LUI_RS5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0);
    check("lui_no_stall", DEF, FWD_ON ? 2'b10 : 2'b00, 2'b00);

    // Load feeding a branch: stall(s) first, then the full control penalty.
    drive(BNE2_0, 1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0);
    check("bne_lu", STALL, FWD_ON ? 2'b10 : 2'b00, 2'b00);
    drive(BNE2_0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1);
    if (FWD_ON) begin
      check("bne_c0", FREEZE, 2'b01, 2'b00);
    end else begin
      check("bne_mem_stall", STALL, 2'b00, 2'b00);
      drive(BNE2_0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      check("bne_c0", FREEZE, 2'b00, 2'b00);
    end
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("bne_c1", FREEZE, 2'b00, 2'b00);
    check("bne_c2", FREEZE, 2'b00, 2'b00);
    check("bne_done", DEF, 2'b00, 2'b00);

    // ALU producer in EX then MEM: two stalls without forwarding.
    drive(OR8_7_0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0);
    check("or_ex", FWD_ON ? DEF : STALL, FWD_ON ? 2'b10 : 2'b00, 2'b00);
    drive(OR8_7_0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1);
    check("or_mem", FWD_ON ? DEF : STALL, FWD_ON ? 2'b01 : 2'b00, 2'b00);
    drive(OR8_7_0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("or_go", DEF, 2'b00, 2'b00);

    // JALR depending on a load stalls; JAL freezes directly.
    drive(JALR0_1, 1'b1, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0);
    check("jalr_lu", STALL, FWD_ON ? 2'b10 : 2'b00, 2'b00);
    drive(JAL1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("jal_c0", FREEZE, 2'b00, 2'b00);
    drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    check("jal_c1", FREEZE, 2'b00, 2'b00);
    check("jal_c2", FREEZE, 2'b00, 2'b00);
    check("jal_done", DEF, 2'b00, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
